csr_exec_ctrl: RTL and testbench
================================

# csr_exec_ctrl

Non-speculative execution sequencer for CSR instructions. It sits between the CSR reservation station's issue packet and the architectural CSR file. It buffers issued CSR operations in a small in-order FIFO and holds each one until it reaches the ROB head. It then performs the read-modify-write on the CSR file and broadcasts the destination physical tag (`CSR_phy`/`CSR_done`) so that waiting reservation-station entries wake up.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of two.
- `PHY_W`, 8: physical register tag width.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: issue packet valid.
- `in_inst_num` in 32: instruction number.
- `in_rd` in PHY_W: destination physical tag.
- `in_op` in 4: CSR operation; 4'h1=RW, 4'h2=RS, 4'h3=RC, anything else = no-write.
- `in_src_imm` in 1: 1 selects the zimm source, 0 selects the register source.
- `in_op1_phy` in PHY_W: source physical tag.
- `in_csr_addr` in 12: CSR address.
- `in_imm` in 32: immediate; only bits [4:0] are used (zimm).
- `prf_raddr` out PHY_W: combinational; equals the head entry's `op1_phy`.
- `prf_rdata` in 32: physical register file data for `prf_raddr`, valid in the same cycle.
- `csr_raddr` out 12: combinational; equals the head entry's CSR address.
- `csr_rdata` in 32: CSR file read data, valid in the same cycle.
- `rob_head_inst` in 32: instruction number at the ROB head.
- `flush` in 1: pipeline flush.
- `csr_we` out 1: registered one-cycle CSR file write pulse.
- `csr_waddr` out 12: registered CSR write address.
- `csr_wdata` out 32: registered CSR write data.
- `CSR_done` out 1: registered one-cycle wakeup pulse.
- `CSR_phy` out PHY_W: tag broadcast with `CSR_done`.
- `CSR_result` out 32: old CSR value written to Rd.
- `full` out 1: `count == DEPTH`; gates RS issue.
- `count` out clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; set by a push attempted while full.

## Operation
- FIFO: head/tail pointers wrap modulo DEPTH.
  - Push when `in_valid && !full && !flush`.
  - Pop at the end of the EXEC state.
  - Push and pop in the same cycle leave `count` unchanged.
- A push while `full` is dropped and sets `overflow`. `full` is judged on the current count, so a same-cycle pop does not admit the push.
- FSM states: IDLE, WAIT, EXEC.
  - IDLE: go to WAIT if `count != 0`.
  - WAIT: go to EXEC when `rob_head_inst == head.inst_num`; otherwise stay in WAIT.
  - EXEC: compute, register the outputs, pop. Go to WAIT if `count > 1` after the pop accounting, else go to IDLE.
- Source value `s` in EXEC: `{27'b0, head.imm[4:0]}` if `src_imm`, else `prf_rdata`.
- New CSR value:
  - RW: `s`.
  - RS: `csr_rdata | s`.
  - RC: `csr_rdata & ~s`.
- Write suppression: `csr_we` is 0 for RS/RC with `s == 0` and for any no-write op. `CSR_done` is always raised.
- `CSR_result` is `csr_rdata` as sampled in EXEC.
- Flush:
  - Clears the FIFO (count 0, pointers 0) and forces IDLE.
  - Suppresses the outputs that the EXEC cycle would have registered; a flush during EXEC aborts the write.
  - A `csr_we`/`CSR_done` pulse already registered in the flush cycle still completes.
  - Flush does not clear `overflow`.
- Reset: state IDLE, count 0, pointers 0, and every output register 0 (`csr_we`, `csr_waddr`, `csr_wdata`, `CSR_done`, `CSR_phy`, `CSR_result`, `overflow`). `full` reads 0.

## Timing
- Cycle 0: `in_valid`; the entry is written at the edge.
- Cycle 1: IDLE sees `count=1`.
- Cycle 2: WAIT; ROB head matches.
- Cycle 3: EXEC.
- Cycle 4: `csr_we`/`CSR_done` high.
- Minimum in_valid-to-`CSR_done` latency is 4 cycles.
- Back-to-back committed entries produce one `CSR_done` every 2 cycles (WAIT, EXEC alternate).
- `csr_we` and `CSR_done` are high for exactly one cycle per executed entry, in the same cycle.
- `csr_waddr`, `csr_wdata`, `CSR_phy` and `CSR_result` hold their values until the next EXEC.
- `prf_raddr` and `csr_raddr` follow the head combinationally and are meaningful only in EXEC.

## Test plan
- Reset, then a single RW:
  - Stimulus: mtvec (12'h305), imm source = 0, `prf_rdata`=32'h8000_0100, `csr_rdata`=32'h0, `rob_head_inst` equals the instruction number.
  - Required: cycle 4 shows `csr_we=1`, `csr_wdata`=32'h8000_0100, `CSR_result`=0, `CSR_done=1`, `CSR_phy`=`in_rd`.
- RS and RC with zimm:
  - RS with zimm=5'h08 on old value 32'h0000_0003 writes 32'h0000_000B.
  - RC with zimm=5'h01 on old value 32'h0000_000B writes 32'h0000_000A.
  - RS with zimm=0 gives `csr_we=0` and `CSR_done=1`.
- Commit wait:
  - Stimulus: push inst 7 with `rob_head_inst`=5 for 10 cycles, then set it to 7.
  - Required: `CSR_done` exactly 2 cycles after the match cycle; nothing before.
- Fill and overflow:
  - Stimulus: push 5 packets on consecutive cycles with the ROB head mismatched.
  - Required: `count`=4, `full`=1, `overflow`=1, fifth packet dropped. After the heads match, exactly 4 `CSR_done` pulses in FIFO order, 2 cycles apart.
- Flush during EXEC:
  - Stimulus: assert `flush` in the EXEC cycle with 3 entries queued.
  - Required: no `csr_we` or `CSR_done` follows, `count`=0, state IDLE. A push asserted in the same cycle as the flush is dropped.
- Reset mid-operation:
  - Stimulus: `reset` in the WAIT state with 2 entries queued.
  - Required: next cycle all outputs are 0, `count`=0, `overflow`=0.

Source files
------------

// File: rtl/csr_exec_ctrl.sv
// rtl/csr_exec_ctrl.sv - In-order CSR execution sequencer: buffers issued CSR ops,
// waits for each to reach the ROB head, then performs the read-modify-write and wakes dependents.
module csr_exec_ctrl #(
    parameter int DEPTH = 4,
    parameter int PHY_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_inst_num,
    input  logic [PHY_W-1:0]           in_rd,
    input  logic [3:0]                 in_op,
    input  logic                       in_src_imm,
    input  logic [PHY_W-1:0]           in_op1_phy,
    input  logic [11:0]                in_csr_addr,
    input  logic [31:0]                in_imm,
    output logic [PHY_W-1:0]           prf_raddr,
    input  logic [31:0]                prf_rdata,
    output logic [11:0]                csr_raddr,
    input  logic [31:0]                csr_rdata,
    input  logic [31:0]                rob_head_inst,
    input  logic                       flush,
    output logic                       csr_we,
    output logic [11:0]                csr_waddr,
    output logic [31:0]                csr_wdata,
    output logic                       CSR_done,
    output logic [PHY_W-1:0]           CSR_phy,
    output logic [31:0]                CSR_result,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC} state_t;
    state_t state;

    logic [31:0]      mem_inst   [DEPTH];
    logic [PHY_W-1:0] mem_rd     [DEPTH];
    logic [3:0]       mem_op     [DEPTH];
    logic             mem_src    [DEPTH];
    logic [PHY_W-1:0] mem_op1    [DEPTH];
    logic [11:0]      mem_addr   [DEPTH];
    logic [4:0]       mem_imm    [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [31:0]   src_val, new_val;
    logic          we_c;
    logic          unused_imm_hi;

    assign unused_imm_hi = ^in_imm[31:5];

    assign full      = (count == CW'(DEPTH));
    assign push      = in_valid && !full && !flush;
    assign pop       = (state == S_EXEC) && !flush;
    assign prf_raddr = mem_op1[rd_ptr];
    assign csr_raddr = mem_addr[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Set/clear ops with an all-zero source must not touch the CSR (no side effects).
    always_comb begin
        src_val = mem_src[rd_ptr] ? {27'b0, mem_imm[rd_ptr]} : prf_rdata;
        new_val = csr_rdata;
        we_c    = 1'b0;
        case (mem_op[rd_ptr])
            4'h1: begin
                new_val = src_val;
                we_c    = 1'b1;
            end
            4'h2: begin
                new_val = csr_rdata | src_val;
                we_c    = (src_val != 32'b0);
            end
            4'h3: begin
                new_val = csr_rdata & ~src_val;
                we_c    = (src_val != 32'b0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= in_inst_num;
            mem_rd[wr_ptr]   <= in_rd;
            mem_op[wr_ptr]   <= in_op;
            mem_src[wr_ptr]  <= in_src_imm;
            mem_op1[wr_ptr]  <= in_op1_phy;
            mem_addr[wr_ptr] <= in_csr_addr;
            mem_imm[wr_ptr]  <= in_imm[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            csr_we     <= 1'b0;
            csr_waddr  <= '0;
            csr_wdata  <= '0;
            CSR_done   <= 1'b0;
            CSR_phy    <= '0;
            CSR_result <= '0;
            overflow   <= 1'b0;
        end else begin
            csr_we   <= 1'b0;
            CSR_done <= 1'b0;
            if (in_valid && full)
                overflow <= 1'b1;
            if (flush) begin
                state  <= S_IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
                case (state)
                    S_IDLE: if (count != '0) state <= S_WAIT;
                    S_WAIT: if (rob_head_inst == mem_inst[rd_ptr]) state <= S_EXEC;
                    S_EXEC: begin
                        csr_we     <= we_c;
                        csr_waddr  <= mem_addr[rd_ptr];
                        csr_wdata  <= new_val;
                        CSR_done   <= 1'b1;
                        CSR_phy    <= mem_rd[rd_ptr];
                        CSR_result <= csr_rdata;
                        state      <= (count > CW'(1)) ? S_WAIT : S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_exec_ctrl.sv
// tb/tb_csr_exec_ctrl.sv - Self-checking bench for csr_exec_ctrl: vector table, directed
// corner sequences and randomized traffic against an in-order scoreboard model.
module tb_csr_exec_ctrl;
    localparam int DEPTH = 4;
    localparam int PHY_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [31:0]       in_inst_num;
    logic [PHY_W-1:0]  in_rd;
    logic [3:0]        in_op;
    logic              in_src_imm;
    logic [PHY_W-1:0]  in_op1_phy;
    logic [11:0]       in_csr_addr;
    logic [31:0]       in_imm;
    logic [PHY_W-1:0]  prf_raddr;
    logic [31:0]       prf_rdata;
    logic [11:0]       csr_raddr;
    logic [31:0]       csr_rdata;
    logic [31:0]       rob_head_inst;
    logic              flush;
    logic              csr_we;
    logic [11:0]       csr_waddr;
    logic [31:0]       csr_wdata;
    logic              CSR_done;
    logic [PHY_W-1:0]  CSR_phy;
    logic [31:0]       CSR_result;
    logic              full;
    logic [$clog2(DEPTH):0] count;
    logic              overflow;

    csr_exec_ctrl #(.DEPTH(DEPTH), .PHY_W(PHY_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst_num(in_inst_num),
        .in_rd(in_rd), .in_op(in_op), .in_src_imm(in_src_imm), .in_op1_phy(in_op1_phy),
        .in_csr_addr(in_csr_addr), .in_imm(in_imm), .prf_raddr(prf_raddr),
        .prf_rdata(prf_rdata), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .rob_head_inst(rob_head_inst), .flush(flush), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .CSR_done(CSR_done),
        .CSR_phy(CSR_phy), .CSR_result(CSR_result), .full(full), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Register file and CSR file stand-ins: fixed values for directed tests, tables for random.
    logic        use_mem;
    logic [31:0] prf_fix, csr_fix;
    logic [31:0] prf_mem [256];
    logic [31:0] csr_mem [4096];
    always_comb begin
        prf_rdata = use_mem ? prf_mem[prf_raddr] : prf_fix;
        csr_rdata = use_mem ? csr_mem[csr_raddr] : csr_fix;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_push(input logic [31:0] inst, input logic [PHY_W-1:0] rd,
                              input logic [3:0] op, input logic si, input logic [PHY_W-1:0] op1,
                              input logic [11:0] addr, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_inst_num = inst;
        in_rd       = rd;
        in_op       = op;
        in_src_imm  = si;
        in_op1_phy  = op1;
        in_csr_addr = addr;
        in_imm      = imm;
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic si, input logic [31:0] imm,
                                      input logic [31:0] prfv, input logic [31:0] csrv,
                                      output logic we, output logic [31:0] nv);
        logic [31:0] s;
        s = si ? (imm & 32'h1F) : prfv;
        case (op)
            4'h1: begin we = 1'b1;         nv = s;           end
            4'h2: begin we = (s != 0);     nv = csrv | s;    end
            4'h3: begin we = (s != 0);     nv = csrv & ~s;   end
            default: begin we = 1'b0;      nv = csrv;        end
        endcase
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic        si;
        logic [31:0] imm;
        logic [31:0] prf;
        logic [31:0] csr;
        logic [11:0] addr;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        logic [31:0]      inst;
        logic [PHY_W-1:0] rd;
        logic [PHY_W-1:0] op1;
        logic [3:0]       op;
        logic             si;
        logic [11:0]      addr;
        logic [31:0]      imm;
    } ent_t;

    vec_t vecs [10];
    ent_t sb [$];

    task automatic check_done_vs_sb();
        ent_t e;
        logic ewe;
        logic [31:0] enew;
        if (CSR_done) begin
            if (sb.size() == 0) begin
                chk("rnd_spurious_done", 32'(CSR_done), 32'd0);
            end else begin
                e = sb.pop_front();
                ref_model(e.op, e.si, e.imm, prf_mem[e.op1], csr_mem[e.addr], ewe, enew);
                chk("rnd_we", 32'(csr_we), 32'(ewe));
                chk("rnd_phy", 32'(CSR_phy), 32'(e.rd));
                chk("rnd_result", CSR_result, csr_mem[e.addr]);
                chk("rnd_waddr", 32'(csr_waddr), 32'(e.addr));
                if (ewe) chk("rnd_wdata", csr_wdata, enew);
            end
        end
    endtask

    initial begin
        int ndone;
        ent_t e;

        vecs[0] = '{4'h1, 1'b0, 32'h0,         32'h8000_0100, 32'h0,  12'h305, 1'b1, 32'h8000_0100};
        vecs[1] = '{4'h2, 1'b1, 32'h08,        32'h0,         32'h3,  12'h300, 1'b1, 32'h0000_000B};
        vecs[2] = '{4'h3, 1'b1, 32'h01,        32'h0,         32'hB,  12'h300, 1'b1, 32'h0000_000A};
        vecs[3] = '{4'h2, 1'b1, 32'h00,        32'hFFFF,      32'hB,  12'h300, 1'b0, 32'h0};
        vecs[4] = '{4'h3, 1'b0, 32'h1F,        32'h0,         32'h5,  12'h341, 1'b0, 32'h0};
        vecs[5] = '{4'h3, 1'b0, 32'h0,         32'hF0,        32'hFF, 12'h342, 1'b1, 32'h0000_000F};
        vecs[6] = '{4'h0, 1'b0, 32'h0,         32'h1234,      32'h77, 12'h343, 1'b0, 32'h0};
        vecs[7] = '{4'h7, 1'b1, 32'h1F,        32'h1234,      32'h77, 12'h344, 1'b0, 32'h0};
        vecs[8] = '{4'h2, 1'b1, 32'hFFFF_FFE4, 32'h0,         32'h10, 12'h345, 1'b1, 32'h0000_0014};
        vecs[9] = '{4'h1, 1'b1, 32'h0,         32'hABCD,      32'h99, 12'h346, 1'b1, 32'h0};

        reset = 1'b1; in_valid = 1'b0; in_inst_num = '0; in_rd = '0; in_op = '0;
        in_src_imm = 1'b0; in_op1_phy = '0; in_csr_addr = '0; in_imm = '0;
        rob_head_inst = 32'hDEAD_0000; flush = 1'b0; use_mem = 1'b0; prf_fix = '0; csr_fix = '0;
        for (int i = 0; i < 256; i++)  prf_mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        for (int i = 0; i < 4096; i++) csr_mem[i] = $urandom;

        repeat (2) @(negedge clk);
        chk("rst_we", 32'(csr_we), 0);
        chk("rst_done", 32'(CSR_done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_outs", {20'(csr_waddr) | 32'(CSR_phy) | csr_wdata | CSR_result}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single-op vectors with the ROB head already matching: 4-cycle latency, 1-cycle pulses.
        for (int i = 0; i < 10; i++) begin
            prf_fix = vecs[i].prf;
            csr_fix = vecs[i].csr;
            rob_head_inst = 1000 + i;
            drive_push(1000 + i, 8'(8'h10 + i), vecs[i].op, vecs[i].si, 8'h3, vecs[i].addr, vecs[i].imm);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (k < 4) chk($sformatf("vec%0d_early_done", i), 32'(CSR_done), 0);
            end
            chk($sformatf("vec%0d_done", i), 32'(CSR_done), 1);
            chk($sformatf("vec%0d_we", i), 32'(csr_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_result", i), CSR_result, vecs[i].csr);
            chk($sformatf("vec%0d_phy", i), 32'(CSR_phy), 32'(8'h10 + i));
            chk($sformatf("vec%0d_waddr", i), 32'(csr_waddr), 32'(vecs[i].addr));
            if (vecs[i].exp_we) chk($sformatf("vec%0d_wdata", i), csr_wdata, vecs[i].exp_wd);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_end", i), 32'({csr_we, CSR_done}), 0);
        end

        // Commit wait: ROB head mismatched for 10 cycles, then matches.
        prf_fix = 32'h1234; csr_fix = 32'h0;
        rob_head_inst = 5;
        drive_push(7, 8'h77, 4'h1, 1'b0, 8'h1, 12'h305, 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (CSR_done) ndone++;
        end
        chk("wait_no_early_done", 32'(ndone), 0);
        rob_head_inst = 7;
        @(negedge clk);
        chk("wait_done_plus1", 32'(CSR_done), 0);
        @(negedge clk);
        chk("wait_done_plus2", 32'(CSR_done), 1);
        chk("wait_phy", 32'(CSR_phy), 32'h77);
        @(negedge clk);

        // Randomized traffic against the in-order scoreboard.
        use_mem = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_done_vs_sb();
            in_valid = 1'b0;
            if (!full && $urandom_range(0, 2) == 0) begin
                e.inst = 5000 + cyc;
                e.rd   = 8'($urandom);
                e.op1  = 8'($urandom);
                e.op   = 4'($urandom_range(0, 4));
                e.si   = 1'($urandom);
                e.addr = 12'($urandom);
                e.imm  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
                drive_push(e.inst, e.rd, e.op, e.si, e.op1, e.addr, e.imm);
                sb.push_back(e);
            end
            rob_head_inst = (sb.size() > 0 && $urandom_range(0, 1) == 1) ? sb[0].inst : 32'hFFFF_FFFF;
        end
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            check_done_vs_sb();
            if (sb.size() > 0) rob_head_inst = sb[0].inst;
        end
        chk("rnd_drained", 32'(sb.size()), 0);
        chk("rnd_no_overflow", 32'(overflow), 0);
        use_mem = 1'b0;
        rob_head_inst = 32'hDEAD_0000;
        repeat (3) @(negedge clk);

        // Fill and overflow: five pushes, fifth dropped.
        for (int j = 0; j < 5; j++) begin
            drive_push(100 + j, 8'(8'h40 + j), 4'h1, 1'b1, 8'h0, 12'(12'h100 + j), j + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_overflow", 32'(overflow), 1);
        for (int j = 0; j < 4; j++) begin
            rob_head_inst = 100 + j;
            @(negedge clk);
            chk($sformatf("fill_gap%0d", j), 32'(CSR_done), 0);
            @(negedge clk);
            chk($sformatf("fill_done%0d", j), 32'(CSR_done), 1);
            chk($sformatf("fill_order%0d", j), 32'(CSR_phy), 32'(8'h40 + j));
            chk($sformatf("fill_wdata%0d", j), csr_wdata, j + 1);
        end
        rob_head_inst = 104;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (CSR_done) ndone++;
        end
        chk("fill_fifth_dropped", 32'(ndone), 0);
        chk("fill_empty", 32'(count), 0);

        // Flush during EXEC with three entries queued; a same-cycle push is dropped.
        rob_head_inst = 32'hDEAD_0000;
        for (int j = 0; j < 3; j++) begin
            drive_push(200 + j, 8'(8'h60 + j), 4'h1, 1'b1, 8'h0, 12'h200, 5);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rob_head_inst = 200;
        @(negedge clk);
        chk("flush_pre_done", 32'(CSR_done), 0);
        flush = 1'b1;
        drive_push(203, 8'h63, 4'h1, 1'b1, 8'h0, 12'h200, 5);
        rob_head_inst = 203;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_no_we", 32'(csr_we), 0);
        chk("flush_no_done", 32'(CSR_done), 0);
        chk("flush_count", 32'(count), 0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (CSR_done || csr_we) ndone++;
        end
        chk("flush_quiet", 32'(ndone), 0);
        chk("flush_count_after", 32'(count), 0);
        chk("flush_keeps_overflow", 32'(overflow), 1);

        // Reset while waiting with two entries queued.
        rob_head_inst = 32'hDEAD_0000;
        for (int j = 0; j < 2; j++) begin
            drive_push(300 + j, 8'(8'h70 + j), 4'h1, 1'b0, 8'h0, 12'h300, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        chk("mid_rst_pulses", 32'({csr_we, CSR_done}), 0);
        chk("mid_rst_waddr", 32'(csr_waddr), 0);
        chk("mid_rst_wdata", csr_wdata, 0);
        chk("mid_rst_phy", 32'(CSR_phy), 0);
        chk("mid_rst_result", CSR_result, 0);
        chk("mid_rst_full", 32'(full), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
